data_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port `Data_Memory` between two requesters: port 0 (CPU load/store stage, stalled while waiting) and port 1 (secondary master, e.g. a debug/loader or result-scan engine). It serialises requests into one memory access at a time. It drives the memory's address, write data, read and write strobes. It returns registered read data with a one-cycle acknowledge. Out-of-range addresses are rejected without touching memory.

---
 rtl/data_mem_arbiter_if.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 103 ++++++++++
 tb/tb_data_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side bundle for the two-port data memory arbiter.
// The slave modport is the arbiter; master is the requesters plus the memory.
interface data_mem_arbiter_if #(
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [DW-1:0] addr0;
  logic [DW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic          err;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [DW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_read_value;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_read_value,
    output ack0, ack1, err, rdata, busy,
    output mem_address, mem_write_data,
    output mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_read_value,
    input  ack0, ack1, err, rdata, busy,
    input  mem_address, mem_write_data,
    input  mem_read, mem_write
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two
// requesters; one access per IDLE/ACCESS/RESP pass, registered read data.
module data_mem_arbiter #(
  parameter int DEPTH = 4096,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);

  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;
  logic [DW-1:0] win_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    win      = 1'b0;
    win_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On contention the port not granted last time wins
          win      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          win_addr = win ? bus.addr1 : bus.addr0;
          id_d     = win;
          last_d   = win;
          we_d     = win ? bus.we1 : bus.we0;
          wdata_d  = win ? bus.wdata1 : bus.wdata0;
          addr_d   = win_addr;
          oor_d    = win_addr >= DEPTH_W;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (we_q || oor_q) ? '0 : bus.mem_read_value;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode from state so an async reset kills them at once
  assign bus.mem_read       = (state_q == ACCESS) && !we_q && !oor_q;
  assign bus.mem_write      = (state_q == ACCESS) && we_q && !oor_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.ack0           = (state_q == RESP) && !id_q;
  assign bus.ack1           = (state_q == RESP) && id_q;
  assign bus.err            = (state_q == RESP) && oor_q;
  assign bus.rdata          = rdata_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_data_mem_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   wr_pulses = 0;
  int   ack0_cnt = 0;
  int   ack1_cnt = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DW(DW)) bus ();

  data_mem_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_val(input int a);
    case (a)
      0:       return 32'h1111_1111;
      10:      return 32'h0000_0077;
      2000:    return 32'h0000_00AB;
      4095:    return 32'h0F0F_0F0F;
      default: return 32'(a) ^ 32'hA5A5_0000;
    endcase
  endfunction

  logic [31:0] mem [0:DEPTH-1];

  assign bus.mem_read_value = (bus.mem_address < DEPTH) ?
                              mem[bus.mem_address[11:0]] : '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (bus.mem_write && bus.mem_address < DEPTH) begin
      mem[bus.mem_address[11:0]] <= bus.mem_write_data;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_write) wr_pulses++;
    if (bus.ack0) ack0_cnt++;
    if (bus.ack1) ack1_cnt++;
  end

  // Reference memory: initial contents plus every accepted write
  logic [31:0] ref_wr [int];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_val(int'(a));
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic do_single(input vec_t v);
    int w0;
    logic valid;
    valid = !v.exp_err;
    w0 = wr_pulses;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    check("acc_busy", bus.busy, 1);
    check("acc_mem_read", bus.mem_read, valid && !v.we);
    check("acc_mem_write", bus.mem_write, valid && v.we);
    check("acc_mem_address", bus.mem_address, v.addr);
    @(negedge clk);
    check("resp_ack0", bus.ack0, v.port == 0);
    check("resp_ack1", bus.ack1, v.port == 1);
    check("resp_err", bus.err, v.exp_err);
    check("resp_rdata", bus.rdata, v.exp_rdata);
    check("resp_strobes", {bus.mem_read, bus.mem_write}, 0);
    drive(v.port, 1'b0, 1'b0, '0, '0);
    if (valid && v.we) ref_wr[int'(v.addr)] = v.wdata;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_acks", {bus.ack0, bus.ack1}, 0);
    check("write_pulses", wr_pulses - w0, (valid && v.we) ? 1 : 0);
  endtask

  vec_t vecs [10];

  logic        pend [2];
  logic        pwe [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  int          pwait [2];

  initial begin
    int a0, a1;
    vecs[0] = '{0, 1'b0, 32'd2000, 32'h0, 32'h0000_00AB, 1'b0};
    vecs[1] = '{1, 1'b1, 32'd2004, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[2] = '{1, 1'b0, 32'd2004, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{0, 1'b1, 32'd4096, 32'h5, 32'h0, 1'b1};
    vecs[4] = '{0, 1'b0, 32'd0, 32'h0, 32'h1111_1111, 1'b0};
    vecs[5] = '{1, 1'b0, 32'd4095, 32'h0, 32'h0F0F_0F0F, 1'b0};
    vecs[6] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h99, 32'h0, 1'b1};
    vecs[7] = '{0, 1'b0, 32'd4095, 32'h0, 32'h0F0F_0F0F, 1'b0};
    vecs[8] = '{0, 1'b1, 32'd4095, 32'h55, 32'h0, 1'b0};
    vecs[9] = '{1, 1'b0, 32'd4095, 32'h0, 32'h0000_0055, 1'b0};

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("rst_acks", {bus.ack0, bus.ack1}, 0);
    check("rst_err_busy", {bus.err, bus.busy}, 0);
    check("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_mem_write_data", bus.mem_write_data, 0);
    mem_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) do_single(vecs[i]);

    // Contention held from reset: 0,1,0,1 with 3-cycle spacing
    rst = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd2000, '0);
    drive(1, 1'b1, 1'b0, 32'd2004, '0);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("cont_ack0_c%0d", c), bus.ack0, c == 2 || c == 8);
      check($sformatf("cont_ack1_c%0d", c), bus.ack1, c == 5 || c == 11);
      if (c == 2) check("cont_rdata0", bus.rdata, ref_read(32'd2000));
      if (c == 5) check("cont_rdata1", bus.rdata, ref_read(32'd2004));
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);

    // Reset during a write access
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    drive(0, 1'b1, 1'b1, 32'd10, 32'h1234);
    @(negedge clk);
    check("abort_write_before", bus.mem_write, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_write_dropped", bus.mem_write, 0);
    check("abort_busy", bus.busy, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_word10", mem[10], ref_read(32'd10));
    check("abort_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
    check("abort_idle", bus.busy, 0);
    drive(0, 1'b1, 1'b0, 32'd10, '0);
    drive(1, 1'b1, 1'b0, 32'd0, '0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ack0", bus.ack0, 1);
    check("post_rst_ack1", bus.ack1, 0);
    check("post_rst_rdata", bus.rdata, ref_read(32'd10));
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);

    // Port 1 rises during port 0's ACCESS
    drive(0, 1'b1, 1'b0, 32'd0, '0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'd4095, '0);
    @(negedge clk);
    check("late_ack0", bus.ack0, 1);
    check("late_ack1_early", bus.ack1, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("late_idle", bus.busy, 0);
    @(negedge clk);
    check("late_access", bus.mem_read, 1);
    @(negedge clk);
    check("late_ack1", bus.ack1, 1);
    check("late_rdata", bus.rdata, ref_read(32'd4095));
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Randomized traffic against the transaction-level model
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      pwait[p] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1)
        check("rand_single_ack", bus.ack0 && bus.ack1, 0);
      for (int p = 0; p < 2; p++) begin
        logic ackp;
        logic oor;
        ackp = (p == 0) ? bus.ack0 : bus.ack1;
        if (ackp) begin
          check($sformatf("rand_ack%0d_had_req", p), pend[p], 1);
          if (pend[p]) begin
            oor = paddr[p] >= DEPTH;
            check($sformatf("rand_err%0d", p), bus.err, oor);
            check($sformatf("rand_rdata%0d", p), bus.rdata,
                  (oor || pwe[p]) ? 32'h0 : ref_read(paddr[p]));
            check($sformatf("rand_wait%0d", p), pwait[p] <= 9, 1);
            if (!oor && pwe[p]) ref_wr[int'(paddr[p])] = pwdata[p];
          end
          pend[p] = 1'b0;
          drive(p, 1'b0, 1'b0, '0, '0);
        end else if (pend[p]) begin
          pwait[p]++;
          if (pwait[p] > 12) begin
            check($sformatf("rand_timeout%0d", p), 1, 0);
            pend[p] = 1'b0;
            drive(p, 1'b0, 1'b0, '0, '0);
          end
        end else if ($urandom_range(0, 1) == 1) begin
          int r;
          r = $urandom_range(0, 9);
          pwe[p] = 1'($urandom_range(0, 1));
          if (r == 0) paddr[p] = 32'(4096 + $urandom_range(0, 100));
          else if (r == 1) paddr[p] = $urandom | 32'h8000_0000;
          else paddr[p] = 32'(3000 + $urandom_range(0, 7));
          pwdata[p] = $urandom;
          pwait[p] = 0;
          pend[p] = 1'b1;
          drive(p, 1'b1, pwe[p], paddr[p], pwdata[p]);
        end
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
